regfile_wb_scheduler: RTL and testbench

// Shares the register file's single write port between two writeback requesters (ALU pipe, load/memory unit)
// and keeps a per-register busy scoreboard that stalls decode/issue on RAW/WAW hazards. Sits between the

---
 rtl/regfile_wb_scheduler.sv | 74 +++++++
 tb/tb_regfile_wb_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: arbitrates ALU/load writebacks onto one register-file write port and keeps a busy scoreboard that stalls issue on RAW/WAW hazards
// Ports: clk/reset (sync, active-high); issue_* in, issue_stall out; alu_wb_* and mem_wb_* valid/addr/data in, *_ready out;
//        rf_write_enable/addr/data drive the register file; busy_mask scoreboard; wb_error sticky stray-writeback flag.
module regfile_wb_scheduler #(
   parameter int ADDR_WIDTH   = 5,
   parameter int DATA_WIDTH   = 64,
   parameter int NUM_REGS     = 32,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rs1,
   input  logic [ADDR_WIDTH-1:0] issue_rs2,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   input  logic                  issue_writes_rd,
   output logic                  issue_stall,
   input  logic                  alu_wb_valid,
   input  logic [ADDR_WIDTH-1:0] alu_wb_addr,
   input  logic [DATA_WIDTH-1:0] alu_wb_data,
   output logic                  alu_wb_ready,
   input  logic                  mem_wb_valid,
   input  logic [ADDR_WIDTH-1:0] mem_wb_addr,
   input  logic [DATA_WIDTH-1:0] mem_wb_data,
   output logic                  mem_wb_ready,
   output logic                  rf_write_enable,
   output logic [ADDR_WIDTH-1:0] rf_write_addr,
   output logic [DATA_WIDTH-1:0] rf_write_data,
   output logic [NUM_REGS-1:0]   busy_mask,
   output logic                  wb_error
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   logic [NUM_REGS-1:0]   busy, busy_next;
   logic [CW-1:0]         starve_cnt;
   logic                  grant, issue_fire;
   logic [ADDR_WIDTH-1:0] grant_addr;
   logic [DATA_WIDTH-1:0] grant_data;
   assign busy_mask    = busy;
   assign issue_stall  = issue_valid & (busy[issue_rs1] | busy[issue_rs2] | (issue_writes_rd & busy[issue_rd]));
   assign issue_fire   = issue_valid & ~issue_stall;
   // loads win ties unless the ALU has lost STARVE_LIMIT times in a row
   assign alu_wb_ready = alu_wb_valid & (~mem_wb_valid | starve_cnt == CW'(STARVE_LIMIT));
   assign mem_wb_ready = mem_wb_valid & ~alu_wb_ready;
   assign grant        = alu_wb_ready | mem_wb_ready;
   assign grant_addr   = alu_wb_ready ? alu_wb_addr : mem_wb_addr;
   assign grant_data   = alu_wb_ready ? alu_wb_data : mem_wb_data;
   // clear on the commit edge, then set so a same-cycle set wins
   always_comb begin
      busy_next = busy;
      if (rf_write_enable && rf_write_addr != '0) busy_next[rf_write_addr] = 1'b0;
      if (issue_fire && issue_writes_rd && issue_rd != '0) busy_next[issue_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         busy            <= '0;
         starve_cnt      <= '0;
         rf_write_enable <= 1'b0;
         rf_write_addr   <= '0;
         rf_write_data   <= '0;
         wb_error        <= 1'b0;
      end else begin
         busy            <= busy_next;
         rf_write_enable <= grant;
         if (grant) begin
            rf_write_addr <= grant_addr;
            rf_write_data <= grant_data;
         end
         starve_cnt <= (~alu_wb_valid | alu_wb_ready) ? '0 :
                       (starve_cnt == CW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + CW'(1);
         wb_error   <= wb_error | (grant & grant_addr != '0 & ~busy[grant_addr]);
      end
   end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed scenarios plus randomized traffic checked every cycle against a behavioural model
module tb_regfile_wb_scheduler;
   localparam int AW = 5, DW = 64, NR = 32, SL = 3;
   logic clk = 1'b0, reset = 1'b1;
   logic issue_valid = 0, issue_writes_rd = 0, issue_stall;
   logic [AW-1:0] issue_rs1 = 0, issue_rs2 = 0, issue_rd = 0;
   logic alu_wb_valid = 0, alu_wb_ready, mem_wb_valid = 0, mem_wb_ready;
   logic [AW-1:0] alu_wb_addr = 0, mem_wb_addr = 0, rf_write_addr;
   logic [DW-1:0] alu_wb_data = 0, mem_wb_data = 0, rf_write_data;
   logic rf_write_enable, wb_error;
   logic [NR-1:0] busy_mask;
   int checks = 0, errors = 0;
   bit chk_en = 0;
   bit a_acc, m_acc, stalled;
   // model state: set of pending registers, loss streak, pending write, sticky error
   bit mb[NR];
   int m_lost;
   bit m_we, m_err;
   int m_addr;
   logic [DW-1:0] m_data;

   regfile_wb_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
      .issue_writes_rd(issue_writes_rd), .issue_stall(issue_stall),
      .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
      .mem_wb_valid(mem_wb_valid), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data), .mem_wb_ready(mem_wb_ready),
      .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
      .busy_mask(busy_mask), .wb_error(wb_error));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
      a_acc = alu_wb_ready;
      m_acc = mem_wb_ready;
      stalled = issue_stall;
   endtask

   // compare, then advance the model to the state after the coming edge
   always @(negedge clk) begin
      bit alu_g, mem_g, e_stall;
      logic [NR-1:0] e_mask;
      int g_addr;
      e_stall = issue_valid && ((issue_rs1 != 0 && mb[issue_rs1]) || (issue_rs2 != 0 && mb[issue_rs2]) ||
                                (issue_writes_rd && issue_rd != 0 && mb[issue_rd]));
      alu_g = alu_wb_valid && (!mem_wb_valid || m_lost >= SL);
      mem_g = mem_wb_valid && !alu_g;
      for (int i = 0; i < NR; i++) e_mask[i] = (i != 0) && mb[i];
      if (chk_en) begin
         chk("m_stall", {63'd0, issue_stall}, {63'd0, e_stall});
         chk("m_alu_ready", {63'd0, alu_wb_ready}, {63'd0, alu_g});
         chk("m_mem_ready", {63'd0, mem_wb_ready}, {63'd0, mem_g});
         chk("m_rf_we", {63'd0, rf_write_enable}, {63'd0, m_we});
         if (m_we) begin
            chk("m_rf_addr", 64'(rf_write_addr), 64'(m_addr));
            chk("m_rf_data", rf_write_data, m_data);
         end
         chk("m_busy", 64'(busy_mask), 64'(e_mask));
         chk("m_wb_error", {63'd0, wb_error}, {63'd0, m_err});
      end
      if (reset) begin
         foreach (mb[i]) mb[i] = 0;
         m_lost = 0; m_we = 0; m_err = 0; m_addr = 0; m_data = '0;
      end else begin
         g_addr = alu_g ? int'(alu_wb_addr) : int'(mem_wb_addr);
         if ((alu_g || mem_g) && g_addr != 0 && !mb[g_addr]) m_err = 1;
         if (m_we && m_addr != 0) mb[m_addr] = 0;
         if (!e_stall && issue_valid && issue_writes_rd && issue_rd != 0) mb[issue_rd] = 1;
         m_lost = (alu_wb_valid && !alu_g) ? ((m_lost + 1 > SL) ? SL : m_lost + 1) : 0;
         m_we = alu_g || mem_g;
         if (m_we) begin
            m_addr = g_addr;
            m_data = alu_g ? alu_wb_data : mem_wb_data;
         end
      end
   end

   function automatic logic [AW-1:0] pick();
      int s;
      s = $urandom_range(0, NR - 1);
      if ($urandom_range(0, 99) < 85)
         for (int k = 0; k < NR; k++) if (mb[(s + k) % NR] && (s + k) % NR != 0) return AW'((s + k) % NR);
      return AW'(s);
   endfunction

   initial begin
      // reset held two cycles
      tick(); tick();
      settle();
      chk("rst_busy", 64'(busy_mask), 64'd0);
      chk("rst_we", {63'd0, rf_write_enable}, 64'd0);
      chk("rst_err", {63'd0, wb_error}, 64'd0);
      chk("rst_ready", {62'd0, alu_wb_ready, mem_wb_ready}, 64'd0);
      chk_en = 1;
      reset = 0;
      // RAW hazard on x5 cleared by an ALU writeback
      issue_valid = 1; issue_rd = 5; issue_writes_rd = 1;
      settle();
      chk("raw_issue", {63'd0, issue_stall}, 64'd0);
      tick();
      issue_rs1 = 5; issue_rd = 0; issue_writes_rd = 0;
      alu_wb_valid = 1; alu_wb_addr = 5; alu_wb_data = 64'h1234;
      settle();
      chk("raw_stall", {63'd0, issue_stall}, 64'd1);
      chk("raw_busy", 64'(busy_mask), 64'h20);
      chk("raw_grant", {63'd0, alu_wb_ready}, 64'd1);
      tick();
      alu_wb_valid = 0;
      settle();
      chk("raw_we", {63'd0, rf_write_enable}, 64'd1);
      chk("raw_addr", 64'(rf_write_addr), 64'd5);
      chk("raw_data", rf_write_data, 64'h1234);
      chk("raw_still_stall", {63'd0, issue_stall}, 64'd1);
      tick();
      settle();
      chk("raw_unstall", {63'd0, issue_stall}, 64'd0);
      chk("raw_busy_clr", 64'(busy_mask), 64'd0);
      issue_valid = 0; issue_rs1 = 0;
      // x0 destination and writeback
      tick();
      issue_valid = 1; issue_rd = 0; issue_writes_rd = 1;
      tick();
      issue_valid = 0; issue_writes_rd = 0;
      mem_wb_valid = 1; mem_wb_addr = 0; mem_wb_data = 64'hAB;
      settle();
      chk("x0_busy", 64'(busy_mask), 64'd0);
      chk("x0_grant", {63'd0, mem_wb_ready}, 64'd1);
      tick();
      mem_wb_valid = 0;
      settle();
      chk("x0_we", {62'd0, rf_write_enable, wb_error}, 64'd2);
      chk("x0_addr", 64'(rf_write_addr), 64'd0);
      // starvation rotation with both requesters always valid
      tick();
      alu_wb_valid = 1; alu_wb_addr = 0; mem_wb_valid = 1; mem_wb_addr = 0;
      for (int i = 0; i < 8; i++) begin
         settle();
         chk("starve_pattern", {62'd0, alu_wb_ready, mem_wb_ready}, (i % 4 == 3) ? 64'd2 : 64'd1);
         tick();
      end
      alu_wb_valid = 0; mem_wb_valid = 0;
      // stray writeback to idle x7 sets the sticky error
      tick();
      alu_wb_valid = 1; alu_wb_addr = 7; alu_wb_data = 64'h77;
      tick();
      alu_wb_valid = 0;
      settle();
      chk("err_set", {63'd0, wb_error}, 64'd1);
      tick(); tick();
      settle();
      chk("err_sticky", {63'd0, wb_error}, 64'd1);
      // reset on the cycle of a mem grant
      issue_valid = 1; issue_rd = 9; issue_writes_rd = 1;
      tick();
      issue_valid = 0; issue_writes_rd = 0;
      mem_wb_valid = 1; mem_wb_addr = 9; mem_wb_data = 64'h99;
      reset = 1;
      settle();
      chk("rst_mid_busy", 64'(busy_mask), 64'h200);
      chk("rst_mid_grant", {63'd0, mem_wb_ready}, 64'd1);
      tick();
      reset = 0; mem_wb_valid = 0;
      settle();
      chk("rst_mid_we", {63'd0, rf_write_enable}, 64'd0);
      chk("rst_mid_busy0", 64'(busy_mask), 64'd0);
      chk("rst_mid_err", {63'd0, wb_error}, 64'd0);
      // randomized traffic with valid/ready and stall holding
      a_acc = 0; m_acc = 0; stalled = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         reset = ($urandom_range(0, 299) == 0);
         if (!alu_wb_valid || a_acc) begin
            alu_wb_valid = $urandom_range(0, 99) < 55;
            alu_wb_addr = pick();
            alu_wb_data = {$urandom, $urandom};
         end
         if (!mem_wb_valid || m_acc) begin
            mem_wb_valid = $urandom_range(0, 99) < 55;
            mem_wb_addr = pick();
            mem_wb_data = {$urandom, $urandom};
         end
         if (!(issue_valid && stalled)) begin
            issue_valid = $urandom_range(0, 99) < 50;
            issue_rs1 = AW'($urandom_range(0, 15));
            issue_rs2 = AW'($urandom_range(0, 15));
            issue_rd = AW'($urandom_range(0, 15));
            issue_writes_rd = $urandom_range(0, 99) < 70;
         end
         settle();
         if (reset) begin a_acc = 0; m_acc = 0; end
      end
      tick(); tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
